// File: rtl/branch_pkg.sv
// Shared types for the branch/flag unit: branch type encoding, condition codes, FSM states.
package branch_pkg;

   typedef enum logic [2:0] {
      BR_NONE   = 3'd0,
      BR_UNCOND = 3'd1,
      BR_CBZ    = 3'd2,
      BR_CBNZ   = 3'd3,
      BR_COND   = 3'd4
   } br_type_e;

   localparam logic [3:0] CondEq = 4'd0;
   localparam logic [3:0] CondNe = 4'd1;
   localparam logic [3:0] CondHs = 4'd2;
   localparam logic [3:0] CondLo = 4'd3;
   localparam logic [3:0] CondMi = 4'd4;
   localparam logic [3:0] CondPl = 4'd5;
   localparam logic [3:0] CondVs = 4'd6;
   localparam logic [3:0] CondVc = 4'd7;
   localparam logic [3:0] CondHi = 4'd8;
   localparam logic [3:0] CondLs = 4'd9;
   localparam logic [3:0] CondGe = 4'd10;
   localparam logic [3:0] CondLt = 4'd11;
   localparam logic [3:0] CondGt = 4'd12;
   localparam logic [3:0] CondLe = 4'd13;
   localparam logic [3:0] CondAl = 4'd14;
   localparam logic [3:0] CondNv = 4'd15;

   typedef enum logic {
      StIdle,
      StFlush
   } state_e;

endpackage

// File: rtl/branch_flag_unit_cond_eval.sv
// Combinational B.cond evaluator over an {N,Z,C,V} flag vector.
module cond_eval
   import branch_pkg::*;
(
   input  logic [3:0] flags,
   input  logic [3:0] cond,
   output logic       pass
);

   logic n, z, c, v, gt;

   assign n  = flags[3];
   assign z  = flags[2];
   assign c  = flags[1];
   assign v  = flags[0];
   assign gt = !z && (n == v);

   always_comb begin
      pass = 1'b1;
      case (cond)
         CondEq:  pass = z;
         CondNe:  pass = !z;
         CondHs:  pass = c;
         CondLo:  pass = !c;
         CondMi:  pass = n;
         CondPl:  pass = !n;
         CondVs:  pass = v;
         CondVc:  pass = !v;
         CondHi:  pass = c && !z;
         CondLs:  pass = !(c && !z);
         CondGe:  pass = (n == v);
         CondLt:  pass = (n != v);
         CondGt:  pass = gt;
         CondLe:  pass = !gt;
         default: pass = 1'b1; // AL and NV both always pass
      endcase
   end

endmodule

// File: rtl/branch_flag_unit.sv
// EX-stage branch resolution with NZCV register and IF/ID flush sequencing.
// Optional BRANCH_STATS_EN adds a 32-bit taken_count output.
module branch_flag_unit
   import branch_pkg::*;
#(
   parameter int unsigned ADDR_W       = 64,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   input  logic              ex_set_flags,
   input  logic              ex_neg,
   input  logic              ex_zero,
   input  logic              ex_carry,
   input  logic              ex_ovf,
   input  logic [2:0]        ex_br_type,
   input  logic [3:0]        ex_cond,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic [ADDR_W-1:0] ex_imm,
   output logic              br_taken,
   output logic [ADDR_W-1:0] br_target,
   output logic              flush,
   output logic [3:0]        flags
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]       taken_count
`endif
);

   localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

   state_e            stateQ, stateD;
   logic [2:0]        cntQ, cntD;
   logic [3:0]        flagsQ;
   logic              brTakenQ;
   logic [ADDR_W-1:0] brTargetQ;
   logic [ADDR_W-1:0] targetD;
   logic              accept, condPass, takenD, takeNow;

   // Conditions see the flags as registered, before this cycle's update.
   cond_eval uCondEval (
      .flags (flagsQ),
      .cond  (ex_cond),
      .pass  (condPass)
   );

   assign accept  = ex_valid && (stateQ == StIdle);
   assign targetD = ex_pc + (ex_imm << 2);
   assign takeNow = accept && takenD;

   always_comb begin
      takenD = 1'b0;
      case (ex_br_type)
         BR_UNCOND: takenD = 1'b1;
         BR_CBZ:    takenD = ex_zero;
         BR_CBNZ:   takenD = !ex_zero;
         BR_COND:   takenD = condPass;
         default:   takenD = 1'b0;
      endcase
   end

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (takeNow) begin
               stateD = StFlush;
               cntD   = FlushLoad;
            end
         end
         StFlush: begin
            if (cntQ == 3'd0) stateD = StIdle;
            else              cntD   = cntQ - 3'd1;
         end
         default: stateD = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stateQ    <= StIdle;
         cntQ      <= 3'd0;
         flagsQ    <= 4'd0;
         brTakenQ  <= 1'b0;
         brTargetQ <= '0;
      end else begin
         stateQ   <= stateD;
         cntQ     <= cntD;
         brTakenQ <= takeNow;
         if (takeNow) brTargetQ <= targetD;
         if (accept && ex_set_flags) flagsQ <= {ex_neg, ex_zero, ex_carry, ex_ovf};
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] takenCountQ;

   always_ff @(posedge clk) begin
      if (reset)         takenCountQ <= 32'd0;
      else if (brTakenQ) takenCountQ <= takenCountQ + 32'd1;
   end

   assign taken_count = takenCountQ;
`endif

   assign br_taken  = brTakenQ;
   assign br_target = brTargetQ;
   assign flush     = (stateQ == StFlush);
   assign flags     = flagsQ;

endmodule

// File: doc/branch_flag_unit.md
BRANCH_FLAG_UNIT -- requirements
Module: branch_flag_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, width of PC, offset and target.
REQ-002 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush stays high after a taken branch (legal range 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ex_valid  input  1  EX-stage instruction valid.
REQ-006 SHALL have port ex_set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS).
REQ-007 SHALL have ports ex_neg, ex_zero, ex_carry, ex_ovf  input  1 each  ALU flags of current EX result; ex_zero comes from the 64-bit zero detector.
REQ-008 SHALL have port ex_br_type  input  3  branch type, encoded as br_type_e.
REQ-009 SHALL have port ex_cond  input  4  B.cond condition code.
REQ-010 SHALL have ports ex_pc and ex_imm  input  ADDR_W each  instruction PC and sign-extended word offset.
REQ-011 SHALL have port br_taken  output  1  registered one-cycle taken pulse.
REQ-012 SHALL have port br_target  output  ADDR_W  registered branch target, valid while br_taken=1.
REQ-013 SHALL have port flush  output  1  squash request to IF/ID.
REQ-014 SHALL have port flags  output  4  architectural NZCV register as {N,Z,C,V}.

Function
REQ-015 SHALL treat EX inputs as accepted only when ex_valid=1 and state=IDLE; in FLUSH, inputs SHALL be ignored (no flag write, no branch resolve).
REQ-016 SHALL load flags <= {ex_neg,ex_zero,ex_carry,ex_ovf} on an accepted cycle with ex_set_flags=1; otherwise flags hold.
REQ-017 SHALL resolve B.cond with the registered flags value from before the current-cycle update; a cycle with both set_flags and BR_COND uses old flags.
REQ-018 SHALL evaluate conditions: 0 EQ Z, 1 NE !Z, 2 HS C, 3 LO !C, 4 MI N, 5 PL !N, 6 VS V, 7 VC !V, 8 HI C&!Z, 9 LS !(C&!Z), 10 GE N==V, 11 LT N!=V, 12 GT !Z&(N==V), 13 LE !GT, 14/15 AL true.
REQ-019 SHALL take BR_UNCOND always, BR_CBZ when ex_zero=1, BR_CBNZ when ex_zero=0, BR_COND per REQ-018, BR_NONE and codes 5-7 never.
REQ-020 SHALL compute target = ex_pc + (ex_imm << 2) modulo 2^ADDR_W (wrap, no overflow detection).
REQ-021 SHALL have latency 1: accepted taken in cycle N -> br_taken=1, br_target valid, flush=1 in cycle N+1.
REQ-022 SHALL implement FSM IDLE/FLUSH: IDLE->FLUSH on accepted taken branch, loading counter with FLUSH_CYCLES-1; FLUSH decrements each cycle and returns to IDLE in the cycle after counter=0.
REQ-023 SHALL drive flush=1 exactly FLUSH_CYCLES consecutive cycles, starting the cycle br_taken=1.
REQ-024 SHALL hold br_target from its last taken branch while br_taken=0.

Reset
REQ-025 SHALL on reset=1 at a clock edge set flags=0, br_taken=0, br_target=0, flush=0, state=IDLE, counter=0, regardless of state, including mid-flush.
REQ-026 SHALL ignore all EX inputs in a cycle with reset=1.

Configuration
REQ-027 SHALL with BRANCH_STATS_EN defined add output taken_count (32 bits), reset to 0, incremented on each br_taken=1 cycle, wrapping at 2^32.
REQ-028 SHALL without BRANCH_STATS_EN omit the taken_count port and counter; all other behaviour identical.

Structure
REQ-029 SHALL place br_type_e (BR_NONE=0, BR_UNCOND=1, BR_CBZ=2, BR_CBNZ=3, BR_COND=4), cond-code constants and the FSM state enum in shared package branch_pkg.
REQ-030 SHALL implement REQ-018 as combinational sub-module cond_eval (inputs flags, cond; output pass).

Verification
REQ-031 SHALL cover: SUBS 5-5 (set_flags, Z=1,C=1) cycle 0, BR_COND EQ cycle 1, pc=0x100, imm=4 -> cycle 2 br_taken=1, br_target=0x110, flush=1 cycles 2-3, 0 in cycle 4.
REQ-032 SHALL cover: flags=0b1000 (N=1,V=0), BR_COND with GE -> not taken; with LT -> taken.
REQ-033 SHALL cover: BR_CBZ with ex_zero=1 pc=0x40, imm=-2 -> br_target=0x38; BR_CBNZ with ex_zero=1 -> no br_taken.
REQ-034 SHALL cover: taken branch then BR_UNCOND and set_flags during flush cycles -> no second br_taken, flags unchanged.
REQ-035 SHALL cover: reset asserted in first flush cycle -> next cycle flush=0, flags=0, state IDLE; branch accepted in the following cycle.
REQ-036 SHALL cover: pc=0xFFFF_FFFF_FFFF_FFFC, imm=1, BR_UNCOND -> br_target=0x0; with BRANCH_STATS_EN, taken_count increments by 1.
